// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        KILL  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    // Sequential PC step, 32-bit modulo (0xFFFF_FFFC wraps to 0).
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/grant/response bus, one outstanding request.
interface fetch_ctrl_if;

    logic        IReq;
    logic [31:0] IAddr;
    logic        IGnt;
    logic        IRValid;
    logic [31:0] IRData;

    modport master (output IReq, output IAddr,
                    input  IGnt, input  IRValid, input IRData);
    modport slave  (input  IReq, input  IAddr,
                    output IGnt, output IRValid, output IRData);

endinterface

// File: rtl/fetch_dreg.sv
// Fetch->Decode pipeline register: reset > flush > stall > load > bubble.
module fetch_dreg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    // Decode slot update; anything not flushed, held or loaded becomes a bubble.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= 32'h0;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (i_stall) begin
            r_instr    <= r_instr;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= pc_plus4(i_pc);
            r_valid    <= 1'b1;
        end else begin
            r_instr    <= NOP_INSTR;
            r_pc       <= 32'h0;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns PCF, sequences fetches, applies redirects/stalls.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master imem,
    input  logic         StallF,
    input  logic         StallD,
    input  logic         FlushD,
    input  logic         PCSrcE,
    input  logic [31:0]  PCTargetE,
    output logic [31:0]  InstrD,
    output logic [31:0]  PCD,
    output logic [31:0]  PCPlus4D,
    output logic         ValidD,
    output logic         FetchBusy
);

    fetch_state_t r_state;
    logic [31:0]  r_pcf;
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_hold_pc;

    logic         w_req;
    logic         w_gnt;
    logic         w_load;
    logic [31:0]  w_instr;
    logic [31:0]  w_pc;

    // A grant only counts when a request is actually on the bus.
    assign w_req      = (r_state == ISSUE) && !StallF && !reset;
    assign w_gnt      = w_req && imem.IGnt;
    assign imem.IReq  = w_req;
    assign imem.IAddr = r_pcf;
    assign FetchBusy  = ((r_state == WAIT) || (r_state == KILL)) && !reset;

    // Select what (if anything) is delivered to the decode slot this cycle.
    always_comb begin
        w_load  = 1'b0;
        w_instr = r_hold_instr;
        w_pc    = r_pcf;
        if (r_state == WAIT && imem.IRValid && !PCSrcE && !FlushD && !StallD) begin
            w_load  = 1'b1;
            w_instr = imem.IRData;
        end else if (r_state == HOLD && !PCSrcE && !StallD && !FlushD) begin
            w_load  = 1'b1;
            w_pc    = r_hold_pc;
        end
    end

    // Fetch FSM and PC: KILL absorbs the response of a request made stale by a redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ISSUE;
            r_pcf        <= RESET_PC;
            r_hold_instr <= 32'h0;
            r_hold_pc    <= 32'h0;
        end else begin
            case (r_state)
                ISSUE: begin
                    if (PCSrcE) begin
                        r_pcf <= PCTargetE;
                        if (w_gnt) r_state <= KILL;
                    end else if (w_gnt) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem.IRValid) begin
                        if (PCSrcE) begin
                            r_pcf   <= PCTargetE;
                            r_state <= ISSUE;
                        end else if (FlushD) begin
                            r_state <= ISSUE;   // refetch same PC
                        end else if (StallD) begin
                            r_hold_instr <= imem.IRData;
                            r_hold_pc    <= r_pcf;
                            r_state      <= HOLD;
                        end else begin
                            r_pcf   <= pc_plus4(r_pcf);
                            r_state <= ISSUE;
                        end
                    end else if (PCSrcE) begin
                        r_pcf   <= PCTargetE;
                        r_state <= KILL;
                    end
                end
                KILL: begin
                    if (PCSrcE)       r_pcf   <= PCTargetE;
                    if (imem.IRValid) r_state <= ISSUE;
                end
                HOLD: begin
                    if (PCSrcE) begin
                        r_pcf   <= PCTargetE;
                        r_state <= ISSUE;
                    end else if (!StallD && !FlushD) begin
                        r_pcf   <= pc_plus4(r_pcf);
                        r_state <= ISSUE;
                    end else if (FlushD) begin
                        r_state <= ISSUE;
                    end
                end
                default: r_state <= ISSUE;
            endcase
        end
    end

    fetch_dreg u_dreg (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (FlushD),
        .i_stall    (StallD),
        .i_load     (w_load),
        .i_instr    (w_instr),
        .i_pc       (w_pc),
        .o_instr    (InstrD),
        .o_pc       (PCD),
        .o_pc_plus4 (PCPlus4D),
        .o_valid    (ValidD)
    );

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the 5-stage RISC-V pipeline. It owns PCF and sequences fetches against an instruction memory with a request/grant/response handshake and one outstanding request. It applies branch/jump redirects from Execute (PCSrcE/PCTargetE) and stall/flush controls from the hazard unit. It drives the Fetch→Decode register (InstrD, PCD, PCPlus4D) plus a valid bit.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched after reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- StallF  in  1  suppress issuing a new fetch request
- StallD  in  1  hold Fetch→Decode register
- FlushD  in  1  load bubble into Fetch→Decode register
- PCSrcE  in  1  redirect request from Execute
- PCTargetE  in  32  redirect target
- IReq  out  1  fetch request valid
- IAddr  out  32  fetch address (= PCF)
- IGnt  in  1  memory accepts request this cycle
- IRValid  in  1  response data valid
- IRData  in  32  fetched instruction
- InstrD  out  32  decode instruction
- PCD  out  32  decode PC
- PCPlus4D  out  32  PCD + 4
- ValidD  out  1  decode slot holds a real instruction
- FetchBusy  out  1  request outstanding (state WAIT or KILL)

## Operation
- States: ISSUE, WAIT, KILL, HOLD.
- IReq = (state==ISSUE) && !StallF && !reset. IAddr = PCF at all times.
- **ISSUE**
  - PCSrcE=1: PCF←PCTargetE.
    - If IGnt=1 in the same cycle, the stale request was granted. Go to KILL.
    - Otherwise stay in ISSUE.
  - IReq && IGnt (no PCSrcE): go to WAIT.
  - IRValid is ignored.
- **WAIT**
  - IRValid && PCSrcE: drop the response. PCF←PCTargetE. Go to ISSUE.
  - IRValid && FlushD && !PCSrcE: drop the response. PCF unchanged (refetch). Go to ISSUE.
  - IRValid && StallD: capture IRData/PCF into the hold buffer. Go to HOLD.
  - IRValid otherwise: deliver to the decode register. PCF←PCF+4. Go to ISSUE.
  - PCSrcE without IRValid: PCF←PCTargetE. Go to KILL.
- **KILL**
  - PCSrcE: PCF←PCTargetE, stay in KILL.
  - IRValid: drop the response. Go to ISSUE.
- **HOLD**
  - No request is issued.
  - PCSrcE: discard the buffer. PCF←PCTargetE. Go to ISSUE.
  - !StallD && !FlushD: deliver the buffer to the decode register. PCF←PCF+4. Go to ISSUE.
  - FlushD: discard the buffer. PCF unchanged. Go to ISSUE.
- **Decode register update**, priority order:
  1. reset
  2. FlushD → InstrD=NOP_INSTR, ValidD=0, PCD/PCPlus4D=0
  3. StallD → hold
  4. delivery → {IRData or buffer, PC, PC+4, 1}
  5. otherwise bubble (NOP_INSTR, ValidD=0)
- Arithmetic: PC+4 is 32-bit modulo. 0xFFFF_FFFC+4 wraps to 0. PCTargetE is used unmodified; no alignment check.

## Timing
- Reset values: state=ISSUE, PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, hold buffer cleared. IReq=0 and FetchBusy=0 while reset=1.
- Reset mid-operation returns to these values on the next edge. Any IRValid arriving in ISSUE afterwards is ignored. The memory shares the same reset.
- Latency:
  - With IGnt in the issue cycle and IRValid one cycle later, the instruction appears on InstrD at the edge that accepts IRValid.
  - Peak throughput is 1 instruction per 2 cycles.
- One outstanding request at most. A new IReq is never asserted before the previous response is consumed or dropped.
- IReq/IAddr are stable while IGnt=0 unless PCSrcE changes PCF.

## Structure
- Package fetch_pkg:
  - fetch_state_t enum {ISSUE, WAIT, KILL, HOLD}
  - NOP_INSTR default constant
- One sub-module is natural: fetch_dreg. It is the Fetch→Decode register with flush/stall/load priority. The rest stays in fetch_ctrl.

## Test plan
- Reset, then a memory with IGnt=1 on request and IRValid one cycle later, IRData=0x00500093:
  - IReq=1, IAddr=0x0 in the first cycle after reset.
  - Then ValidD=1, InstrD=0x00500093, PCD=0, PCPlus4D=4.
  - Next IAddr=0x4.
- Redirect in WAIT: PCSrcE=1, PCTargetE=0x40 while the fetch of 0x8 is outstanding:
  - FetchBusy stays 1 (KILL).
  - The late response 0xDEADBEEF is dropped and ValidD=0.
  - Next IReq has IAddr=0x40.
- PCSrcE=1 (target 0x80) in the same cycle as IRValid:
  - The response is dropped.
  - Next IAddr=0x80, ValidD=0.
- StallD=1 when IRValid arrives with 0x00A00113 at PC 0xC:
  - IReq=0 and the decode outputs are unchanged while stalled.
  - StallD→0: InstrD=0x00A00113, PCD=0xC, ValidD=1, then IAddr=0x10.
- StallF=1 in ISSUE for 3 cycles: IReq=0 and IAddr held. Release: IReq=1 with the same IAddr.
- Reset asserted in WAIT:
  - Next edge: ValidD=0, InstrD=0x00000013, IAddr=RESET_PC.
  - A stray IRValid afterwards is ignored.
